// File: rtl/rand_coord_gen.sv
// rand_coord_gen
// Pseudo-random grid-coordinate source for the snake playfield. A 16-bit
// Galois LFSR is seeded from a free-running entropy counter on the first
// start press and produces (X,Y) pairs confined to X in 1..14, Y in 1..10.
// Off-grid candidates are dropped, so the outputs only ever show legal cells.
//
// Ports
//   clk      in   system clock
//   nRst     in   synchronous active-low reset
//   seed_en  in   raw start/button level (asynchronous); rising edge seeds
//   advance  in   step enable for the LFSR
//   s_reset  in   game restart; back to IDLE, valid cleared
//   randX    out  current X coordinate (1..14)
//   randY    out  current Y coordinate (1..10)
//   valid    out  an in-range coordinate has been produced since last seed
//
// Build option
//   RAND_COORD_FIXED_SEED_EN  when defined, every seed load uses SEED_CONST
//                             instead of the entropy counter.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a start press; LFSR and outputs frozen, valid=0
// RUN   | seeded; LFSR steps on advance, in-range candidates published
module rand_coord_gen #(
    parameter int                 LFSR_W     = 16,
    parameter logic [LFSR_W-1:0]  SEED_CONST = 16'hACE1
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       seed_en,
    input  logic       advance,
    input  logic       s_reset,
    output logic [3:0] randX,
    output logic [3:0] randY,
    output logic       valid
);

    localparam logic [LFSR_W-1:0] TAPS = 16'hB400;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [LFSR_W-1:0]  ent_q, ent_d;
    logic               s1_q, s2_q, s3_q;
    logic [3:0]         x_q, x_d;
    logic [3:0]         y_q, y_d;
    logic               valid_q, valid_d;

    logic               rise;
    logic [LFSR_W-1:0]  nxt;
    logic [LFSR_W-1:0]  seed_val;
    logic [3:0]         cx, cy;
    logic               accept;

    assign rise = s2_q & ~s3_q;
    assign nxt  = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    assign cx   = nxt[3:0];
    assign cy   = nxt[7:4];
    assign accept = (cx >= 4'd1) && (cx <= 4'd14) && (cy >= 4'd1) && (cy <= 4'd10);

`ifdef RAND_COORD_FIXED_SEED_EN
    assign seed_val = SEED_CONST;
`else
    // A press at ent == SEED_CONST would seed the all-zero lock-up state.
    logic [LFSR_W-1:0] mix;
    assign mix      = ent_q ^ SEED_CONST;
    assign seed_val = (mix == '0) ? SEED_CONST : mix;
`endif

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        ent_d   = ent_q + 1'b1;
        x_d     = x_q;
        y_d     = y_q;
        valid_d = valid_q;

        if (s_reset) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        lfsr_d  = seed_val;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (advance) begin
                        if (lfsr_q == '0) begin
                            // recovery only; counts as a rejected step
                            lfsr_d = SEED_CONST;
                        end else begin
                            lfsr_d = nxt;
                            if (accept) begin
                                x_d     = cx;
                                y_d     = cy;
                                valid_d = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_CONST;
            ent_q   <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            x_q     <= 4'd1;
            y_q     <= 4'd1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            ent_q   <= ent_d;
            s1_q    <= seed_en;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign randX = x_q;
    assign randY = y_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_rand_coord_gen.sv
module tb_rand_coord_gen;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       seed_en = 1'b0;
    logic       advance = 1'b0;
    logic       s_reset = 1'b0;
    logic [3:0] randX;
    logic [3:0] randY;
    logic       valid;

    int n_checks = 0;
    int n_errors = 0;

    rand_coord_gen dut (
        .clk     (clk),
        .nRst    (nRst),
        .seed_en (seed_en),
        .advance (advance),
        .s_reset (s_reset),
        .randX   (randX),
        .randY   (randY),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [15:0] m_ent   = 16'h0;
    logic [15:0] m_lfsr  = SEED;
    bit          m_run   = 1'b0;
    logic [3:0]  m_x     = 4'd1;
    logic [3:0]  m_y     = 4'd1;
    bit          m_valid = 1'b0;
    bit          sync_q[$] = '{1'b0, 1'b0, 1'b0};   // [0] newest sample
    bit          cov [256];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] seed_for(input logic [15:0] ent);
`ifdef RAND_COORD_FIXED_SEED_EN
        return SEED;
`else
        logic [15:0] v;
        v = ent ^ SEED;
        return (v == 16'h0) ? SEED : v;
`endif
    endfunction

    function automatic logic [15:0] galois(input logic [15:0] v);
        logic [15:0] r;
        r = v / 2;
        if (v % 2 == 1) r = r ^ 16'hB400;
        return r;
    endfunction

    // model of one clock edge, using the inputs as they stand before it
    task automatic model_edge();
        bit rise;
        logic [15:0] n;
        int cx, cy;
        if (!nRst) begin
            m_ent = 0; m_lfsr = SEED; m_run = 0;
            m_x = 1; m_y = 1; m_valid = 0;
            sync_q = '{1'b0, 1'b0, 1'b0};
            return;
        end
        rise = sync_q[1] && !sync_q[2];
        if (s_reset) begin
            m_run = 0;
            m_valid = 0;
        end else if (!m_run) begin
            if (rise) begin
                m_lfsr = seed_for(m_ent);
                m_run = 1;
            end
        end else if (advance) begin
            if (m_lfsr == 0) begin
                m_lfsr = SEED;
            end else begin
                n = galois(m_lfsr);
                m_lfsr = n;
                cx = int'(n % 16);
                cy = int'((n / 16) % 16);
                if (cx >= 1 && cx <= 14 && cy >= 1 && cy <= 10) begin
                    m_x = 4'(cx);
                    m_y = 4'(cy);
                    m_valid = 1;
                end
            end
        end
        m_ent = m_ent + 16'd1;
        sync_q.push_front(seed_en);
        void'(sync_q.pop_back());
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_val("randX", 32'(randX), 32'(m_x));
        check_val("randY", 32'(randY), 32'(m_y));
        check_val("valid", 32'(valid), 32'(m_valid));
        check_val("lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
        check_val("x_range", 32'(randX >= 4'd1 && randX <= 4'd14), 32'd1);
        check_val("y_range", 32'(randY >= 4'd1 && randY <= 4'd10), 32'd1);
    endtask

    initial begin : stim
        logic [15:0] saved;
        int          covered;

        // reset held 3 cycles, then idle with advance=1
        nRst = 1'b0;
        repeat (3) tick();
        nRst = 1'b1;
        advance = 1'b1;
        repeat (20) tick();
        check_val("idle_lfsr", 32'(dut.lfsr_q), 32'hACE1);
        check_val("idle_valid", 32'(valid), 32'd0);

        // press so the load sees ent == ACE1: zero-fallback and known sequence
        while (m_ent != 16'hACDF) tick();
        seed_en = 1'b1;
        tick();
        tick();
        tick();
        check_val("seed_lfsr", 32'(dut.lfsr_q), 32'hACE1);
        tick();
        check_val("step1_lfsr", 32'(dut.lfsr_q), 32'hE270);
        check_val("step1_valid", 32'(valid), 32'd0);
        tick();
        check_val("step2_lfsr", 32'(dut.lfsr_q), 32'h7138);
        check_val("step2_x", 32'(randX), 32'd8);
        check_val("step2_y", 32'(randY), 32'd3);
        check_val("step2_valid", 32'(valid), 32'd1);

        // second press in RUN is ignored
        seed_en = 1'b0;
        repeat (4) tick();
        seed_en = 1'b1;
        repeat (6) tick();

        // advance gating
        advance = 1'b0;
        saved = m_lfsr;
        repeat (10) tick();
        check_val("gate_lfsr", 32'(dut.lfsr_q), 32'(saved));
        advance = 1'b1;
        tick();
        check_val("gate_resume", 32'(dut.lfsr_q), 32'(galois(saved)));

        // range soak with coverage of all 140 cells
        for (int i = 0; i < 256; i++) cov[i] = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            tick();
            if (valid) cov[{randY, randX}] = 1'b1;
        end
        covered = 0;
        for (int i = 0; i < 256; i++) if (cov[i]) covered++;
        check_val("coverage", 32'(covered), 32'd140);

        // game restart
        s_reset = 1'b1;
        tick();
        check_val("restart_valid", 32'(valid), 32'd0);
        s_reset = 1'b0;
        seed_en = 1'b0;
        repeat (3) tick();
        saved = m_lfsr;
        seed_en = 1'b1;
        tick();
        tick();
        s_reset = 1'b1;          // coincides with rise
        tick();
        s_reset = 1'b0;
        repeat (5) tick();
        check_val("sreset_rise_lfsr", 32'(dut.lfsr_q), 32'(saved));
        seed_en = 1'b0;
        repeat (3) tick();
        seed_en = 1'b1;
        tick();
        tick();
        tick();
        check_val("reseed_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
        repeat (20) tick();

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            advance = ($urandom_range(3) != 0);
            s_reset = ($urandom_range(199) == 0);
            if ($urandom_range(39) == 0) seed_en = ~seed_en;
            nRst = (i != 2000);
            tick();
        end
        s_reset = 1'b0;
        nRst = 1'b1;

        // mid-operation reset
        nRst = 1'b0;
        tick();
        check_val("midrst_x", 32'(randX), 32'd1);
        check_val("midrst_y", 32'(randY), 32'd1);
        check_val("midrst_valid", 32'(valid), 32'd0);
        check_val("midrst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
        nRst = 1'b1;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rand_coord_gen.md
# rand_coord_gen

Pseudo-random grid-coordinate source for the snake playfield. Drives the `randX`/`randY` inputs of the obstacle generator (and the apple placer) with coordinates guaranteed inside the 14×10 playable area, X in 1..14 and Y in 1..10. The source is a 16-bit Galois LFSR seeded from a free-running entropy counter at the player's first button press. Out-of-range candidates are rejected, so the outputs are never off-grid.

## Interface
- `LFSR_W`, 16, LFSR and entropy-counter width; fixed at 16 because the taps are defined for 16.
- `SEED_CONST`, 16'hACE1, seed XOR mask and fallback seed.
- `clk`  in  1  system clock.
- `nRst`  in  1  reset; one clock, synchronous, active-low.
- `seed_en`  in  1  raw start/button level, asynchronous to `clk`; its rising edge seeds the generator.
- `advance`  in  1  step enable; the LFSR steps only in cycles where this is 1.
- `s_reset`  in  1  game-restart pulse; forces re-seed on the next start press.
- `randX`  out  4  current X coordinate, always in 1..14.
- `randY`  out  4  current Y coordinate, always in 1..10.
- `valid`  out  1  1 once at least one in-range coordinate has been produced since the last seed.

## Operation
- **Entropy counter `ent`:** 16 bits; increments every cycle from reset and wraps at 16'hFFFF→0. Never held.
- **Start synchroniser:** `seed_en` passes through 2 flops (`s1`, `s2`), then a delayed copy `s3`.
  - `rise = s2 & ~s3`.
- **State machine:** two states, IDLE and RUN.
  - IDLE: LFSR holds; outputs hold; `valid`=0. On `rise`, load the LFSR and go to RUN.
    - Load value: `ent ^ SEED_CONST`.
    - If that value is 16'h0000, load `SEED_CONST` instead.
  - RUN, `advance`=1: `lfsr <= nxt`.
    - `nxt` = the Galois right shift: `(lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0)`.
    - Candidate: `cx = nxt[3:0]`, `cy = nxt[7:4]`.
    - Accept when 1≤`cx`≤14 and 1≤`cy`≤10. On accept, at the same edge: `randX <= cx`, `randY <= cy`, `valid <= 1`.
    - On reject, `randX`/`randY`/`valid` hold.
  - RUN, `advance`=0: everything holds.
  - `rise` while in RUN is ignored; there is one seed per game.
  - `s_reset`=1 in any state: go to IDLE and clear `valid` to 0. `randX`/`randY` hold their values, and the LFSR holds. `s_reset` takes priority over `rise` and over `advance` in the same cycle.
- **LFSR zero state:** unreachable after a legal seed. If 16'h0000 is ever observed in RUN, reload `SEED_CONST` at the next edge instead of stepping; that cycle counts as a reject.
- **Arithmetic:** all comparisons are on unsigned 4-bit fields; no carries.

## Timing
- **Reset values** (`nRst`=0 at an edge):
  - `randX`=1, `randY`=1, `valid`=0.
  - State=IDLE; `lfsr`=`SEED_CONST`; `ent`=0.
  - `s1`/`s2`/`s3`=0.
- **Seed latency:** `seed_en` first sampled high at edge k gives `rise` during cycle k+1→k+2. The LFSR is loaded and RUN entered at edge k+2.
- **First step:** happens at edge k+3 if `advance`=1.
- **Output latency:** an accepted candidate is visible on the outputs in the cycle right after the edge that produced it. There is no combinational path from `advance` to the outputs.
- **Acceptance rate:** 140/256 per step. The longest reject run is bounded by the LFSR sequence, and the outputs stay stable during rejects.
- **Downstream consumer:** samples `randX`/`randY` every cycle and must gate its use on `valid`.
- **Mid-operation `nRst`:** behaves exactly like reset; all state above is restored.

## Configuration
- `RAND_COORD_FIXED_SEED_EN`
  - **Defined:** the seed load ignores `ent` and always loads `SEED_CONST`. The coordinate sequence is then deterministic and independent of press timing; this is for simulation and demo boards.
  - **Undefined:** the seed is `ent ^ SEED_CONST` with the zero fallback, as above.
  - Nothing else changes with the macro.

## Test plan
- **Reset:** hold `nRst`=0 for 3 cycles, then release with `seed_en`=0 and `advance`=1 for 20 cycles → `randX`=1, `randY`=1, `valid`=0 throughout; LFSR still 16'hACE1.
- **Fixed-seed sequence (`RAND_COORD_FIXED_SEED_EN` defined):** raise `seed_en` at edge k, `advance`=1 →
  - edge k+2: `lfsr`=ACE1.
  - edge k+3: `lfsr`=E270; rejected (cx=0); `valid`=0.
  - edge k+4: `lfsr`=7138; `randX`=8, `randY`=3, `valid`=1.
- **Range soak:** seed, then run `advance`=1 for 100 000 cycles → `randX` always in 1..14 and `randY` always in 1..10. Every one of the 140 (X,Y) pairs is observed.
- **Advance gating:** in RUN, drop `advance` to 0 for 10 cycles → `lfsr`, `randX`, `randY` and `valid` are constant; stepping resumes the exact sequence.
- **Game restart:**
  - Pulse `s_reset` while `advance`=1 → the next edge gives `valid`=0, state IDLE, outputs held.
  - A fresh `seed_en` rise re-enters RUN 2 edges later.
  - Asserting `s_reset` together with `rise` keeps the block in IDLE.
- **Entropy seed (macro undefined):** press at `ent`=16'hACE1 → the XOR gives 0 and the fallback loads 16'hACE1. Press at `ent`=16'h0001 → LFSR loads 16'hACE0. A second press while in RUN is ignored.
